// File: rtl/microbenchmark_pkg.sv
// Shared types and constants for the microbenchmark traffic lanes.
// The LFSR polynomial is x^64 + x^63 + x^61 + x^60, shifted left with feedback into bit 0.
package microbenchmark_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} rrg_state_t;

    // Tap mask selects bits 63, 62, 60 and 59.
    localparam logic [63:0] LFSR_TAPS = 64'hD800_0000_0000_0000;
    localparam logic [63:0] LFSR_SEED = 64'hACE1_0000_0000_0001;

    typedef struct packed {
        logic [63:0] num_requests;
        logic [63:0] base_addr;
        logic [63:0] bound;
        logic [63:0] req_size;
        logic [63:0] stride;
        logic        access_pattern;
    } rrg_cfg_t;

endpackage

// File: rtl/lfsr64.sv
// 64-bit Fibonacci LFSR that advances one state per step pulse.
// Asynchronous reset reloads the seed, so every run after reset replays the same sequence.
module lfsr64
    import microbenchmark_pkg::*;
#(
    parameter logic [63:0] SEED = LFSR_SEED
) (
    input  logic        clk,
    input  logic        aresetn,
    input  logic        step,
    output logic [63:0] value
);

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            value <= SEED;
        end else if (step) begin
            value <= {value[62:0], ^(value & LFSR_TAPS)};
        end
    end

endmodule

// File: rtl/read_request_generator.sv
// Per-lane read traffic engine: latches the lane config on a start edge, issues strided or LFSR-random
// reads inside [base_addr, base_addr+bound), bounds reads in flight and reports completion and cycle count.
module read_request_generator
    import microbenchmark_pkg::*;
#(
    parameter int          ADDR_W  = 48,
    parameter int          LEN_W   = 28,
    parameter int          MAX_OUT = 16,
    parameter logic [63:0] SEED    = 64'hACE1_0000_0000_0001
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              ap_start,
    input  logic [63:0]       num_requests,
    input  logic [63:0]       base_addr,
    input  logic [63:0]       bound,
    input  logic [63:0]       req_size,
    input  logic [63:0]       stride,
    input  logic              access_pattern,
    output logic              req_valid,
    input  logic              req_ready,
    output logic [ADDR_W-1:0] req_vaddr,
    output logic [LEN_W-1:0]  req_len,
    input  logic              rd_done,
    output logic              busy,
    output logic              done,
    output logic [63:0]       cycles,
    output logic              err
);

    localparam int OUT_W = $clog2(MAX_OUT) + 1;

    rrg_state_t       state_q, state_d;
    rrg_cfg_t         cfg_q;
    logic             ap_start_q;
    logic [63:0]      issued_q, completed_q, offset_q, cycles_q;
    logic [OUT_W-1:0] outstanding_q;
    logic             err_q;
    logic [63:0]      lfsr_value;

    logic        start_edge, start_run, accept, rd_ok, last_accept, running;
    logic [63:0] seq_sum, seq_next, rand_offset, cur_offset;

    assign start_edge  = ap_start && !ap_start_q;
    assign start_run   = (state_q == IDLE) && start_edge;
    assign running     = (state_q == ISSUE) || (state_q == DRAIN);
    assign req_valid   = (state_q == ISSUE) && (outstanding_q < OUT_W'(MAX_OUT));
    assign accept      = req_valid && req_ready;
    // A completion is only meaningful while something is in flight.
    assign rd_ok       = rd_done && (outstanding_q != '0);
    assign last_accept = accept && ((issued_q + 64'd1) == cfg_q.num_requests);

    // Sequential offsets wrap at most once per step, so stride is expected to be below bound.
    assign seq_sum     = offset_q + cfg_q.stride;
    assign seq_next    = (seq_sum >= cfg_q.bound) ? (seq_sum - cfg_q.bound) : seq_sum;
    assign rand_offset = lfsr_value & (cfg_q.bound - 64'd1) & ~(cfg_q.req_size - 64'd1);
    assign cur_offset  = cfg_q.access_pattern ? rand_offset : offset_q;

    assign req_vaddr = (state_q == ISSUE) ? ADDR_W'(cfg_q.base_addr + cur_offset) : '0;
    assign req_len   = (state_q == ISSUE) ? cfg_q.req_size[LEN_W-1:0] : '0;
    assign busy      = running;
    assign done      = (state_q == DONE);
    assign cycles    = cycles_q;
    assign err       = err_q;

    lfsr64 #(.SEED(SEED)) u_lfsr (
        .clk     (aclk),
        .aresetn (aresetn),
        .step    (accept && cfg_q.access_pattern),
        .value   (lfsr_value)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_edge) state_d = (num_requests == 64'd0) ? DONE : ISSUE;
            ISSUE:   if (last_accept) state_d = DRAIN;
            DRAIN:   if (completed_q == cfg_q.num_requests) state_d = DONE;
            DONE:    if (!ap_start) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= IDLE;
            ap_start_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ap_start_q <= ap_start;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cfg_q       <= '0;
            issued_q    <= '0;
            completed_q <= '0;
            offset_q    <= '0;
            cycles_q    <= '0;
        end else if (start_run) begin
            cfg_q       <= '{num_requests: num_requests, base_addr: base_addr, bound: bound,
                             req_size: req_size, stride: stride, access_pattern: access_pattern};
            issued_q    <= '0;
            completed_q <= '0;
            offset_q    <= '0;
            cycles_q    <= '0;
        end else begin
            if (accept) begin
                issued_q <= issued_q + 64'd1;
                offset_q <= seq_next;
            end
            if (rd_ok) completed_q <= completed_q + 64'd1;
            if (running && (cycles_q != '1)) cycles_q <= cycles_q + 64'd1;
        end
    end

    // Outstanding and err persist across runs; only reset clears them.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            outstanding_q <= '0;
            err_q         <= 1'b0;
        end else begin
            case ({accept, rd_ok})
                2'b10:   outstanding_q <= outstanding_q + OUT_W'(1);
                2'b01:   outstanding_q <= outstanding_q - OUT_W'(1);
                default: outstanding_q <= outstanding_q;
            endcase
            if (rd_done && (outstanding_q == '0)) err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_read_request_generator.sv
// Randomized bench for read_request_generator against a request-level reference model
// that tracks the expected address stream, reads in flight and the sticky error flag.
module tb_read_request_generator;

    localparam int          ADDR_W  = 48;
    localparam int          LEN_W   = 28;
    localparam int          MAX_OUT = 16;
    localparam logic [63:0] SEED    = 64'hACE1_0000_0000_0001;
    localparam logic [63:0] AMASK   = (64'd1 << ADDR_W) - 64'd1;

    logic              aclk = 1'b0;
    logic              aresetn = 1'b0;
    logic              ap_start = 1'b0;
    logic [63:0]       num_requests = '0, base_addr = '0, bound = '0, req_size = '0, stride = '0;
    logic              access_pattern = 1'b0;
    logic              req_valid;
    logic              req_ready = 1'b0;
    logic [ADDR_W-1:0] req_vaddr;
    logic [LEN_W-1:0]  req_len;
    logic              rd_done = 1'b0;
    logic              busy, done, err;
    logic [63:0]       cycles;

    read_request_generator #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .MAX_OUT(MAX_OUT), .SEED(SEED)) dut (
        .aclk(aclk), .aresetn(aresetn), .ap_start(ap_start), .num_requests(num_requests),
        .base_addr(base_addr), .bound(bound), .req_size(req_size), .stride(stride),
        .access_pattern(access_pattern), .req_valid(req_valid), .req_ready(req_ready),
        .req_vaddr(req_vaddr), .req_len(req_len), .rd_done(rd_done), .busy(busy),
        .done(done), .cycles(cycles), .err(err)
    );

    always #5 aclk = ~aclk;

    int n_tests = 0, n_fail = 0;
    int n_acc = 0, pending = 0, e_cyc = 0;
    logic [63:0] m_num = '0, m_base = '0, m_bound = '0, m_size = '0, m_stride = '0;
    logic [63:0] m_off = '0, m_lfsr = SEED;
    bit          m_rand = 1'b0, m_err = 1'b0;
    logic [63:0] got_q[$], first_rand_q[$];
    logic [63:0] seq_exp [6] = '{64'h1000, 64'h1040, 64'h1080, 64'h10C0, 64'h1000, 64'h1040};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] lfsr_next(input logic [63:0] v);
        return {v[62:0], v[63] ^ v[62] ^ v[60] ^ v[59]};
    endfunction

    function automatic logic [63:0] model_addr();
        logic [63:0] off;
        off = m_rand ? (m_lfsr & (m_bound - 64'd1) & ~(m_size - 64'd1)) : m_off;
        return (m_base + off) & AMASK;
    endfunction

    task automatic model_advance();
        if (m_rand) begin
            m_lfsr = lfsr_next(m_lfsr);
        end else begin
            m_off = m_off + m_stride;
            if (m_off >= m_bound) m_off = m_off - m_bound;
        end
    endtask

    // One clock cycle: drive at the falling edge, account for the handshake, return at the next falling edge.
    task automatic step(input bit rdy, input bit rdn);
        bit acc;
        req_ready = rdy;
        rd_done   = rdn;
        chk("req_valid", 64'(req_valid), 64'((64'(n_acc) < m_num) && (pending < MAX_OUT)));
        acc = req_valid && rdy;
        if (acc) begin
            chk("req_vaddr", 64'(req_vaddr), model_addr());
            chk("req_len", 64'(req_len), 64'(m_size[LEN_W-1:0]));
            got_q.push_back(64'(req_vaddr));
            model_advance();
            n_acc++;
        end
        if (rdn) begin
            if (pending == 0) m_err = 1'b1;
            else pending--;
        end
        if (acc) pending++;
        @(posedge aclk);
        @(negedge aclk);
        e_cyc++;
        chk("err", 64'(err), 64'(m_err));
    endtask

    task automatic start_run(input logic [63:0] num, input logic [63:0] base, input logic [63:0] bnd,
                             input logic [63:0] size, input logic [63:0] strd, input bit rnd);
        num_requests = num; base_addr = base; bound = bnd; req_size = size; stride = strd;
        access_pattern = rnd;
        ap_start = 1'b1; req_ready = 1'b0; rd_done = 1'b0;
        m_num = num; m_base = base; m_bound = bnd; m_size = size; m_stride = strd; m_rand = rnd;
        m_off = '0; n_acc = 0;
        got_q.delete();
        @(posedge aclk);
        @(negedge aclk);
        e_cyc = 0;
    endtask

    task automatic run_until_done(input int ready_pct, input int done_pct, input int budget);
        int b = 0;
        while (done !== 1'b1 && b < budget) begin
            step(int'($urandom_range(0, 99)) < ready_pct,
                 (pending > 0) && (int'($urandom_range(0, 99)) < done_pct));
            b++;
        end
        req_ready = 1'b0;
        rd_done   = 1'b0;
        chk("done_reached", 64'(done), 64'd1);
        chk("cycles", cycles, 64'(e_cyc));
        chk("accepts", 64'(n_acc), m_num);
        chk("busy_at_done", 64'(busy), 64'd0);
    endtask

    task automatic finish_run();
        ap_start = 1'b0;
        step(1'b0, 1'b0);
        chk("done_clear", 64'(done), 64'd0);
    endtask

    task automatic model_reset();
        m_lfsr = SEED; m_err = 1'b0; pending = 0; n_acc = 0; m_num = '0;
    endtask

    task automatic apply_reset();
        aresetn = 1'b0; ap_start = 1'b0; req_ready = 1'b0; rd_done = 1'b0;
        model_reset();
        @(negedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        @(negedge aclk);
        @(negedge aclk);
        chk("rst_valid", 64'(req_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_cycles", cycles, 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_vaddr", 64'(req_vaddr), 64'd0);
        apply_reset();

        // Sequential wrap example.
        start_run(64'd6, 64'h1000, 64'h100, 64'h40, 64'h40, 1'b0);
        run_until_done(100, 50, 500);
        for (int i = 0; i < 6; i++) chk("seq_vector", (i < got_q.size()) ? got_q[i] : 64'hX, seq_exp[i]);
        finish_run();

        // Odd stride, 48-bit truncation, CSR changes and ap_start drop mid-run, random handshakes.
        start_run(64'd40, 64'h0001_FFFF_FFFF_FF80, 64'h100, 64'h20, 64'h30, 1'b0);
        ap_start = 1'b0;
        base_addr = 64'hDEAD_0000;
        stride = 64'h8;
        run_until_done(60, 40, 2000);
        finish_run();

        // Random pattern: range, alignment, then replay after reset.
        start_run(64'd64, 64'h2000_0000, 64'h1000, 64'h40, 64'h0, 1'b1);
        run_until_done(70, 40, 3000);
        foreach (got_q[i]) begin
            chk("rand_range", 64'((got_q[i] >= 64'h2000_0000) && (got_q[i] < 64'h2000_1000)), 64'd1);
            chk("rand_align", got_q[i] & 64'h3F, 64'd0);
        end
        first_rand_q = got_q;
        finish_run();
        apply_reset();
        start_run(64'd64, 64'h2000_0000, 64'h1000, 64'h40, 64'h0, 1'b1);
        run_until_done(50, 50, 3000);
        chk("rand_replay_len", 64'(got_q.size()), 64'(first_rand_q.size()));
        foreach (got_q[i]) chk("rand_replay", got_q[i], first_rand_q[i]);
        finish_run();

        // Zero requests; ap_start held high must not start a second run.
        start_run(64'd0, 64'h3000, 64'h100, 64'h40, 64'h40, 1'b0);
        chk("zero_done_now", 64'(done), 64'd1);
        run_until_done(100, 0, 10);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
        chk("zero_hold_done", 64'(done), 64'd1);
        chk("zero_hold_busy", 64'(busy), 64'd0);
        chk("zero_hold_cycles", cycles, 64'd0);
        finish_run();

        // Outstanding cap, single release, and completion coincident with accept.
        start_run(64'd20, 64'h4000, 64'h10000, 64'h40, 64'h40, 1'b0);
        for (int i = 0; i < 30; i++) step(1'b1, 1'b0);
        chk("cap_accepts", 64'(n_acc), 64'd16);
        chk("cap_valid_low", 64'(req_valid), 64'd0);
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
        chk("release_one", 64'(n_acc), 64'd17);
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        chk("simul_valid", 64'(req_valid), 64'd1);
        chk("simul_accepts", 64'(n_acc), 64'd18);
        run_until_done(100, 60, 500);
        finish_run();

        // Spurious completion in IDLE sets a sticky error that survives a run.
        step(1'b0, 1'b1);
        chk("spurious_err", 64'(err), 64'd1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
        start_run(64'd3, 64'h5000, 64'h100, 64'h40, 64'h40, 1'b0);
        run_until_done(100, 50, 200);
        chk("err_sticky", 64'(err), 64'd1);
        finish_run();

        // Asynchronous reset in ISSUE with five reads in flight.
        start_run(64'd30, 64'h2000_0000, 64'h1000, 64'h40, 64'h0, 1'b1);
        while (n_acc < 5) step(1'b1, 1'b0);
        #2 aresetn = 1'b0;
        ap_start = 1'b0;
        req_ready = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(req_valid), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_done", 64'(done), 64'd0);
        chk("mid_rst_cycles", cycles, 64'd0);
        chk("mid_rst_err", 64'(err), 64'd0);
        chk("mid_rst_vaddr", 64'(req_vaddr), 64'd0);
        chk("mid_rst_len", 64'(req_len), 64'd0);
        model_reset();
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        start_run(64'd8, 64'h2000_0000, 64'h1000, 64'h40, 64'h0, 1'b1);
        run_until_done(80, 50, 500);
        for (int i = 0; i < 8; i++)
            chk("post_rst_replay", (i < got_q.size()) ? got_q[i] : 64'hX, first_rand_q[i]);
        finish_run();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
